nvram_upload_reader: RTL

// Upload-side responder for the HPS ioctl channel: the reader that pairs with the ioctl download writer.
// - Serves ioctl_din from a game RAM window while the HPS saves NVRAM/hiscore data.
// - Holds the CPU paused for the whole upload, using a req/ack handshake to the pause system.
// - Raises ioctl_upload_req for autosave once the window is dirty and the CPU has stopped writing to it.

---
 rtl/nvram_upload_reader_if.sv | 28 ++
 rtl/nvram_upload_reader.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/nvram_upload_reader_if.sv
// HPS ioctl upload channel: the HPS side drives the upload/read request,
// the reader answers with read data and raises the autosave request.
interface nvram_upload_reader_if;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_upload_req;

    modport master (
        output ioctl_upload,
        output ioctl_index,
        output ioctl_rd,
        output ioctl_addr,
        input  ioctl_din,
        input  ioctl_upload_req
    );

    modport slave (
        input  ioctl_upload,
        input  ioctl_index,
        input  ioctl_rd,
        input  ioctl_addr,
        output ioctl_din,
        output ioctl_upload_req
    );
endinterface

// File: rtl/nvram_upload_reader.sv
// Upload-side responder for the HPS ioctl channel. Serves bytes from a game
// RAM window while holding the CPU paused, and requests an autosave once
// the window has been written and the CPU has gone quiet on it.
module nvram_upload_reader #(
    parameter int              ADDR_W    = 16,
    parameter logic [7:0]      INDEX     = 8'd4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              LENGTH    = 256,
    parameter int              RAM_LAT   = 1,
    parameter logic [23:0]     IDLE_CYC  = 24'd4_900_000
) (
    input  logic                clk_49m,
    input  logic                reset,
    nvram_upload_reader_if.slave ioctl,
    input  logic                autosave,
    input  logic                mon_wr,
    input  logic [ADDR_W-1:0]   mon_addr,
    output logic                pause_req,
    input  logic                paused,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_rd,
    input  logic [7:0]          ram_q,
    output logic                busy,
    output logic                rd_overrun
);

    typedef enum logic [2:0] {IDLE, WAIT_P, SERVE, RD, REL} state_t;

    state_t      state;
    logic        active;
    logic        active_q;
    logic        pending;
    logic [24:0] pend_addr;
    logic [24:0] req_addr;
    logic        req_valid;
    logic        in_range;
    logic        oob;
    logic [2:0]  lat_cnt;
    logic [7:0]  din;
    logic        upload_req;
    logic        dirty;
    logic [23:0] idle_cnt;
    logic        in_win;
    logic        active_rise;
    logic        fire;

    assign active      = ioctl.ioctl_upload && (ioctl.ioctl_index == INDEX);
    assign active_rise = active && !active_q;
    assign busy        = (state != IDLE);

    assign ioctl.ioctl_din        = din;
    assign ioctl.ioctl_upload_req = upload_req;

    // A read latched before the pause was granted takes priority over a new strobe
    always_comb begin
        req_valid = pending || ioctl.ioctl_rd;
        req_addr  = pending ? pend_addr : ioctl.ioctl_addr;
        in_range  = ({7'd0, req_addr} < 32'(LENGTH));
        in_win    = mon_wr
                    && (32'(mon_addr) >= 32'(BASE_ADDR))
                    && (32'(mon_addr) <  32'(BASE_ADDR) + 32'(LENGTH));
        fire      = dirty && autosave && (idle_cnt == IDLE_CYC) && (state == IDLE);
    end

    // Upload FSM: pause handshake, read sequencing and read data register
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pause_req  <= 1'b0;
            ram_rd     <= 1'b0;
            ram_addr   <= '0;
            din        <= 8'h00;
            rd_overrun <= 1'b0;
            pending    <= 1'b0;
            pend_addr  <= '0;
            lat_cnt    <= '0;
            oob        <= 1'b0;
        end else begin
            ram_rd <= 1'b0;
            case (state)
                IDLE: begin
                    if (active) begin
                        state     <= WAIT_P;
                        pause_req <= 1'b1;
                        if (ioctl.ioctl_rd) begin
                            pending   <= 1'b1;
                            pend_addr <= ioctl.ioctl_addr;
                        end
                    end
                end
                WAIT_P: begin
                    if (!active) begin
                        state     <= REL;
                        pause_req <= 1'b0;
                        pending   <= 1'b0;
                    end else begin
                        if (ioctl.ioctl_rd) begin
                            pending   <= 1'b1;
                            pend_addr <= ioctl.ioctl_addr;
                        end
                        if (paused) begin
                            state <= SERVE;
                        end
                    end
                end
                SERVE: begin
                    if (!active) begin
                        state     <= REL;
                        pause_req <= 1'b0;
                        pending   <= 1'b0;
                    end else if (req_valid) begin
                        pending <= 1'b0;
                        if (pending && ioctl.ioctl_rd) begin
                            rd_overrun <= 1'b1;
                        end
                        lat_cnt <= '0;
                        state   <= RD;
                        if (in_range) begin
                            ram_rd   <= 1'b1;
                            ram_addr <= BASE_ADDR + req_addr[ADDR_W-1:0];
                            oob      <= 1'b0;
                        end else begin
                            oob <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (!active) begin
                        state     <= REL;
                        pause_req <= 1'b0;
                        pending   <= 1'b0;
                    end else begin
                        if (ioctl.ioctl_rd) begin
                            rd_overrun <= 1'b1;
                        end
                        if (oob) begin
                            din   <= 8'hFF;
                            state <= SERVE;
                        end else if (lat_cnt == 3'(RAM_LAT)) begin
                            din   <= ram_q;
                            state <= SERVE;
                        end else begin
                            lat_cnt <= lat_cnt + 3'd1;
                        end
                    end
                end
                REL: begin
                    state     <= IDLE;
                    pause_req <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    pause_req <= 1'b0;
                end
            endcase
        end
    end

    // Dirty tracking, write-idle counter and the one-cycle autosave request
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            active_q   <= 1'b0;
            dirty      <= 1'b0;
            idle_cnt   <= '0;
            upload_req <= 1'b0;
        end else begin
            active_q   <= active;
            upload_req <= 1'b0;
            if (in_win) begin
                dirty    <= 1'b1;
                idle_cnt <= '0;
            end else if (active_rise) begin
                dirty    <= 1'b0;
                idle_cnt <= '0;
            end else if (fire) begin
                upload_req <= 1'b1;
                dirty      <= 1'b0;
                idle_cnt   <= '0;
            end else if (dirty && (idle_cnt != IDLE_CYC)) begin
                idle_cnt <= idle_cnt + 24'd1;
            end
        end
    end

endmodule
